// File: rtl/srv_icache_pkg.sv
// Shared types and address-field width helpers for the set-associative instruction cache.
package srv_icache_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REFILL = 3'd2,
    RESP   = 3'd3,
    FLUSH  = 3'd4
  } state_t;

  // True field width; zero when the field vanishes (n == 1).
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Storage width for a field; never below one bit so vectors stay legal.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int nsets, input int line_words);
    return 30 - field_w(nsets) - field_w(line_words);
  endfunction

endpackage

// File: rtl/srv_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and access update, both combinational.
module srv_plru_tree #(
  parameter int NWAYS = 4,
  localparam int WAYW = $clog2(NWAYS)
) (
  input  logic [NWAYS-2:0] tree,
  input  logic [WAYW-1:0]  way,
  output logic [WAYW-1:0]  victim,
  output logic [NWAYS-2:0] tree_next
);

  // Heap layout: node n has children 2n+1 (left) and 2n+2 (right); a 0 bit points left.
  always_comb begin : walk_victim
    logic [WAYW-1:0] node;
    node   = '0;
    victim = '0;
    for (int lvl = 0; lvl < WAYW; lvl++) begin
      victim[WAYW-1-lvl] = tree[node];
      node = WAYW'(2 * int'(node) + 1 + int'(tree[node]));
    end
  end

  always_comb begin : walk_update
    logic [WAYW-1:0] node;
    node      = '0;
    tree_next = tree;
    for (int lvl = 0; lvl < WAYW; lvl++) begin
      tree_next[node] = ~way[WAYW-1-lvl];
      node = WAYW'(2 * int'(node) + 1 + int'(way[WAYW-1-lvl]));
    end
  end

endmodule

// File: rtl/srv_icache_sa.sv
// Set-associative instruction cache with tree-PLRU replacement, blocking line refill and fence.i flush.
module srv_icache_sa
  import srv_icache_pkg::*;
#(
  parameter int NSETS      = 4,
  parameter int NWAYS      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       imem_req_i,
  input  logic [31:0]                imAddr,
  output logic                       req_rdy_o,
  output logic [31:0]                imData,
  output logic                       im_drdy,
  input  logic                       flush_i,
  output logic                       ext_req_o,
  output logic [31:0]                ext_addr_o,
  input  logic                       ext_rsp_i,
  input  logic [32*LINE_WORDS-1:0]   ext_data_i,
  output logic [2:0]                 dbg_state
);

  localparam int OFFW  = field_w(LINE_WORDS);
  localparam int OFFS  = sel_w(LINE_WORDS);
  localparam int IDXS  = sel_w(NSETS);
  localparam int TAGW  = tag_w(NSETS, LINE_WORDS);
  localparam int WAYW  = $clog2(NWAYS);
  localparam int LINEW = 32 * LINE_WORDS;

  // Handshake: a request transfers on a cycle where imem_req_i && req_rdy_o; the word comes
  // back on the single cycle im_drdy is high, and ext_req_o holds until one ext_rsp_i pulse.
  state_t            state;
  logic [31:0]       addr_q;
  logic              flush_pend;
  logic [31:0]       resp_q;
  logic [NWAYS-1:0]  valid_q [NSETS];
  logic [NWAYS-2:0]  plru_q  [NSETS];
  logic [TAGW-1:0]   tag_mem  [NSETS][NWAYS];
  logic [LINEW-1:0]  data_mem [NSETS][NWAYS];

  logic [IDXS-1:0]   idx;
  logic [OFFS-1:0]   off;
  logic [TAGW-1:0]   tag;
  logic              hit;
  logic [WAYW-1:0]   hit_way;
  logic [WAYW-1:0]   victim;
  logic [WAYW-1:0]   plru_victim;
  logic [NWAYS-2:0]  plru_next;
  logic [LINEW-1:0]  hit_line;
  logic [31:0]       hit_word;
  logic              lookup_hit;

  assign idx = IDXS'((addr_q >> (2 + OFFW)) & 32'(NSETS - 1));
  assign off = OFFS'((addr_q >> 2) & 32'(LINE_WORDS - 1));
  assign tag = addr_q[31 -: TAGW];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
    end
  end

  // Fill an empty way before disturbing the PLRU choice.
  always_comb begin
    victim = plru_victim;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim = WAYW'(w);
    end
  end

  srv_plru_tree #(.NWAYS(NWAYS)) u_plru (
    .tree      (plru_q[idx]),
    .way       ((state == LOOKUP) ? hit_way : victim),
    .victim    (plru_victim),
    .tree_next (plru_next)
  );

  assign hit_line   = data_mem[idx][hit_way];
  assign hit_word   = 32'(hit_line >> {off, 5'b0});
  assign lookup_hit = (state == LOOKUP) && hit;

  assign req_rdy_o  = (state == IDLE) && !flush_pend && !flush_i;
  assign im_drdy    = lookup_hit || (state == RESP);
  assign imData     = lookup_hit ? hit_word : resp_q;
  assign ext_req_o  = (state == REFILL);
  assign ext_addr_o = addr_q & ~32'(LINE_WORDS * 4 - 1);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      flush_pend <= 1'b0;
      resp_q     <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush_i || flush_pend) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
          end else if (imem_req_i) begin
            addr_q <= imAddr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            plru_q[idx] <= plru_next;
            state       <= IDLE;
          end else begin
            state <= REFILL;
          end
        end
        REFILL: begin
          if (ext_rsp_i) begin
            valid_q[idx][victim] <= 1'b1;
            plru_q[idx]          <= plru_next;
            resp_q               <= 32'(ext_data_i >> {off, 5'b0});
            state                <= RESP;
          end
        end
        RESP: state <= IDLE;
        FLUSH: begin
          for (int s = 0; s < NSETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A fence.i arriving mid-transaction waits for the transaction to finish.
      if (flush_i && state != IDLE) flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == REFILL && ext_rsp_i) begin
      data_mem[idx][victim] <= ext_data_i;
      tag_mem[idx][victim]  <= tag;
    end
  end

endmodule

// File: tb/tb_srv_icache_sa.sv
// Bench for srv_icache_sa: directed scenarios plus random fetches against an abstract cache model.
module tb_srv_icache_sa;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         imem_req_i = 1'b0;
  logic [31:0]  imAddr = '0;
  logic         flush_i = 1'b0;
  logic         ext_rsp_i = 1'b0;
  logic [127:0] ext_data_i = '0;
  logic         req_rdy_o;
  logic [31:0]  imData;
  logic         im_drdy;
  logic         ext_req_o;
  logic [31:0]  ext_addr_o;
  logic [2:0]   dbg_state;

  int tests_run = 0;
  int fails = 0;

  srv_icache_sa dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req_i (imem_req_i),
    .imAddr     (imAddr),
    .req_rdy_o  (req_rdy_o),
    .imData     (imData),
    .im_drdy    (im_drdy),
    .flush_i    (flush_i),
    .ext_req_o  (ext_req_o),
    .ext_addr_o (ext_addr_o),
    .ext_rsp_i  (ext_rsp_i),
    .ext_data_i (ext_data_i),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory (lazily randomised) and an abstract 4-set x 4-way cache model.
  logic [127:0] mem [int unsigned];
  bit           mv [4][4];
  logic [25:0]  mt [4][4];
  bit           mp [4][3];
  logic [31:0]  exp_q [$];

  function automatic logic [127:0] line_of(input logic [31:0] a);
    int unsigned key;
    key = a & ~32'hF;
    if (!mem.exists(key)) mem[key] = {$urandom, $urandom, $urandom, $urandom};
    return mem[key];
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [127:0] l;
    l = line_of(a);
    return l[((a >> 2) & 3) * 32 +: 32];
  endfunction

  function automatic void model_find(input logic [31:0] a, output bit h, output int way);
    int s;
    s = (a >> 4) & 3;
    h = 0;
    way = 0;
    for (int w = 0; w < 4; w++)
      if (mv[s][w] && mt[s][w] == a[31:6]) begin h = 1; way = w; end
  endfunction

  function automatic int model_victim(input int s);
    int lo, hi, n, mid;
    for (int w = 0; w < 4; w++) if (!mv[s][w]) return w;
    lo = 0; hi = 4; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (!mp[s][n]) begin hi = mid; n = 2 * n + 1; end
      else begin lo = mid; n = 2 * n + 2; end
    end
    return lo;
  endfunction

  // Every node on the way's path is turned to point to the other half.
  function automatic void model_touch(input int s, input int w);
    int lo, hi, n, mid;
    lo = 0; hi = 4; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin mp[s][n] = 1; hi = mid; n = 2 * n + 1; end
      else begin mp[s][n] = 0; lo = mid; n = 2 * n + 2; end
    end
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 4; w++) mv[s][w] = 0;
      for (int n = 0; n < 3; n++) mp[s][n] = 0;
    end
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_rdy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (req_rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL %s ready: got %b expected 1 within 50 cycles", name, req_rdy_o);
    end
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input bit flush_mid);
    bit          eh, ok;
    int          ew, s, n, v;
    logic [31:0] exp_w, exp_a;
    s = (addr >> 4) & 3;
    model_find(addr, eh, ew);
    exp_q.push_back(word_of(addr));
    exp_a = addr & ~32'hF;
    wait_ready(name);
    imem_req_i = 1'b1;
    imAddr     = addr | 32'($urandom_range(0, 3));
    @(negedge clk);
    imem_req_i = 1'b0;
    tests_run++;
    if (im_drdy !== eh) begin
      fails++;
      $display("FAIL %s hit: drdy got %b expected %b (addr %h)", name, im_drdy, eh, addr);
    end
    exp_w = exp_q.pop_front();
    if (eh) begin
      tests_run++;
      if (imData !== exp_w) begin
        fails++;
        $display("FAIL %s hit_data: got %h expected %h", name, imData, exp_w);
      end
      model_touch(s, ew);
    end else begin
      @(negedge clk);
      tests_run += 2;
      if (ext_req_o !== 1'b1) begin
        fails++;
        $display("FAIL %s ext_req: got %b expected 1", name, ext_req_o);
      end
      if (ext_addr_o !== exp_a) begin
        fails++;
        $display("FAIL %s ext_addr: got %h expected %h", name, ext_addr_o, exp_a);
      end
      flush_i = flush_mid;
      n  = $urandom_range(0, 3);
      ok = 1;
      repeat (n) begin
        @(negedge clk);
        flush_i = 1'b0;
        if (ext_req_o !== 1'b1) ok = 0;
      end
      ext_rsp_i  = 1'b1;
      ext_data_i = line_of(addr);
      @(negedge clk);
      ext_rsp_i = 1'b0;
      flush_i   = 1'b0;
      tests_run += 3;
      if (!ok) begin
        fails++;
        $display("FAIL %s ext_req_hold: dropped during %0d wait cycles, expected held", name, n);
      end
      if (im_drdy !== 1'b1) begin
        fails++;
        $display("FAIL %s resp_drdy: got %b expected 1", name, im_drdy);
      end
      if (imData !== exp_w) begin
        fails++;
        $display("FAIL %s resp_data: got %h expected %h", name, imData, exp_w);
      end
      v = model_victim(s);
      mv[s][v] = 1;
      mt[s][v] = addr[31:6];
      model_touch(s, v);
      if (flush_mid) model_flush();
    end
    @(negedge clk);
    tests_run++;
    if (im_drdy !== 1'b0) begin
      fails++;
      $display("FAIL %s drdy_pulse: got %b expected 0", name, im_drdy);
    end
    if (flush_mid && !eh) begin
      tests_run++;
      if (req_rdy_o !== 1'b0) begin
        fails++;
        $display("FAIL %s pending_flush_rdy: got %b expected 0", name, req_rdy_o);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run += 3;
    if (im_drdy !== 1'b0) begin fails++; $display("FAIL reset drdy: got %b expected 0", im_drdy); end
    if (ext_req_o !== 1'b0) begin fails++; $display("FAIL reset ext_req: got %b expected 0", ext_req_o); end
    if (imData !== 32'h0) begin fails++; $display("FAIL reset imData: got %h expected 0", imData); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run += 2;
    if (req_rdy_o !== 1'b1) begin fails++; $display("FAIL reset rdy: got %b expected 1", req_rdy_o); end
    if (im_drdy !== 1'b0) begin fails++; $display("FAIL reset drdy_after: got %b expected 0", im_drdy); end
    model_flush();
  endtask

  task automatic test_cold_miss();
    fetch("cold_miss", 32'h100, 0);
  endtask

  task automatic test_hit();
    fetch("hit_word3", 32'h10C, 0);
  endtask

  task automatic test_flush_vs_req();
    wait_ready("flush_vs_req");
    flush_i    = 1'b1;
    imem_req_i = 1'b1;
    imAddr     = 32'h10C;
    #1;
    tests_run++;
    if (req_rdy_o !== 1'b0) begin fails++; $display("FAIL flush_vs_req rdy: got %b expected 0", req_rdy_o); end
    @(negedge clk);
    flush_i    = 1'b0;
    imem_req_i = 1'b0;
    tests_run += 2;
    if (im_drdy !== 1'b0) begin fails++; $display("FAIL flush_vs_req drdy: got %b expected 0", im_drdy); end
    if (req_rdy_o !== 1'b0) begin fails++; $display("FAIL flush_vs_req flush_rdy: got %b expected 0", req_rdy_o); end
    model_flush();
    fetch("after_flush_0x10C", 32'h10C, 0);
    fetch("after_flush_0x100", 32'h100, 0);
  endtask

  task automatic test_eviction();
    model_flush();
    wait_ready("evict_prep");
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    fetch("evict_fill0", 32'h000, 0);
    fetch("evict_fill1", 32'h040, 0);
    fetch("evict_fill2", 32'h080, 0);
    fetch("evict_fill3", 32'h0C0, 0);
    fetch("evict_hit0", 32'h000, 0);
    fetch("evict_miss", 32'h100, 0);
    fetch("evict_keep0", 32'h000, 0);
    fetch("evict_probe80", 32'h080, 0);
    fetch("evict_probe40", 32'h040, 0);
  endtask

  task automatic test_flush_refill();
    fetch("flush_refill", 32'h1C0, 1);
    fetch("flush_refill_again", 32'h1C0, 0);
  endtask

  task automatic test_reset_refill();
    wait_ready("reset_refill");
    imem_req_i = 1'b1;
    imAddr     = 32'h3000;
    @(negedge clk);
    imem_req_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ext_req_o !== 1'b1) begin fails++; $display("FAIL reset_refill in_refill: got %b expected 1", ext_req_o); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ext_req_o !== 1'b0) begin fails++; $display("FAIL reset_refill ext_req: got %b expected 0", ext_req_o); end
    @(negedge clk);
    rst_n      = 1'b1;
    ext_rsp_i  = 1'b1;
    ext_data_i = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    ext_rsp_i = 1'b0;
    tests_run += 2;
    if (im_drdy !== 1'b0) begin fails++; $display("FAIL reset_refill stray_drdy: got %b expected 0", im_drdy); end
    if (ext_req_o !== 1'b0) begin fails++; $display("FAIL reset_refill stray_req: got %b expected 0", ext_req_o); end
    model_flush();
    fetch("reset_refill_0x100", 32'h100, 0);
  endtask

  task automatic test_random();
    bit          h;
    int          w;
    logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      a = (32'($urandom_range(0, 23)) << 4) | (32'($urandom_range(0, 3)) << 2);
      model_find(a, h, w);
      fetch("random", a, !h && ($urandom_range(0, 9) == 0));
    end
  endtask

  initial begin
    mem[32'h100] = {$urandom, $urandom, $urandom, 32'h0000_0013};
    test_reset();
    test_cold_miss();
    test_hit();
    test_flush_vs_req();
    test_eviction();
    test_flush_refill();
    test_reset_refill();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
